// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// life_pkg : shared cell-state constants and rule-mask helpers for Life arrays
// Rev 1.0
// ============================================================================
package life_pkg;

   localparam int ST_DEAD  = 0;
   localparam int ST_ALIVE = 1;

   // B3/S23 masks for 8 neighbours; stored wide so narrower neighbourhoods can slice them.
   localparam logic [31:0] LIFE_B3_MASK  = 32'h0000_0008;
   localparam logic [31:0] LIFE_S23_MASK = 32'h0000_000C;

   function automatic int mask_width(input int n_neighbors);
      return n_neighbors + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/generations_cell_if.sv
`default_nettype none
// ============================================================================
// generations_cell_if : control, rule and status bundle of one Generations cell
// Rev 1.0
// ============================================================================
interface generations_cell_if #(
   parameter int N_NEIGHBORS = 8,
   parameter int STATE_W     = 1,
   parameter int CNT_W       = $clog2(N_NEIGHBORS + 1),
   parameter int AGE_W       = 4
);

   logic                                             ena;
   logic [N_NEIGHBORS-1:0]                           neighbors;
   logic [STATE_W-1:0]                               state_0;
   logic                                             rule_load;
   logic [life_pkg::mask_width(N_NEIGHBORS)-1:0]     birth_in;
   logic [life_pkg::mask_width(N_NEIGHBORS)-1:0]     survive_in;
   logic [STATE_W-1:0]                               state_d;
   logic [STATE_W-1:0]                               state_q;
   logic                                             alive;
   logic [CNT_W-1:0]                                 living_count;
   logic [AGE_W-1:0]                                 age_q;

   modport master (
      output ena, neighbors, state_0, rule_load, birth_in, survive_in,
      input  state_d, state_q, alive, living_count, age_q
   );

   modport slave (
      input  ena, neighbors, state_0, rule_load, birth_in, survive_in,
      output state_d, state_q, alive, living_count, age_q
   );

endinterface
`default_nettype wire

// File: rtl/neighbor_popcount.sv
`default_nettype none
// ============================================================================
// neighbor_popcount : zero-extended count of set neighbour alive bits
// Rev 1.0
// ============================================================================
module neighbor_popcount #(
   parameter int N_NEIGHBORS = 8,
   parameter int CNT_W       = $clog2(N_NEIGHBORS + 1)
) (
   input  wire logic [N_NEIGHBORS-1:0] bits_i,
   output logic      [CNT_W-1:0]       count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < N_NEIGHBORS; i++) begin
         count_o = count_o + CNT_W'(bits_i[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/generations_cell.sv
`default_nettype none
// ============================================================================
// generations_cell : programmable Generations cellular-automaton cell
// Rev 1.0
// ============================================================================
module generations_cell
   import life_pkg::*;
#(
   parameter int N_NEIGHBORS = 8,
   parameter int N_STATES    = 2,
   parameter int STATE_W     = (N_STATES > 2) ? $clog2(N_STATES) : 1,
   parameter int CNT_W       = $clog2(N_NEIGHBORS + 1),
   parameter int AGE_W       = 4,
   parameter logic [mask_width(N_NEIGHBORS)-1:0] DEFAULT_BIRTH   = LIFE_B3_MASK[mask_width(N_NEIGHBORS)-1:0],
   parameter logic [mask_width(N_NEIGHBORS)-1:0] DEFAULT_SURVIVE = LIFE_S23_MASK[mask_width(N_NEIGHBORS)-1:0]
) (
   input wire logic          clk,
   input wire logic          rst,
   generations_cell_if.slave bus
);

   localparam int                 c_mask_w         = mask_width(N_NEIGHBORS);
   localparam logic [STATE_W:0]   c_n_states       = (STATE_W + 1)'(N_STATES);
   localparam logic [STATE_W-1:0] c_st_dead        = STATE_W'(ST_DEAD);
   localparam logic [STATE_W-1:0] c_st_alive       = STATE_W'(ST_ALIVE);
   localparam logic [STATE_W-1:0] c_st_last        = STATE_W'(N_STATES - 1);
   // A two-state cell dies straight to dead; otherwise it enters the first refractory state.
   localparam logic [STATE_W-1:0] c_st_after_alive = (N_STATES == 2) ? c_st_dead : STATE_W'(2);
   localparam logic [AGE_W-1:0]   c_age_max        = '1;

   logic [STATE_W-1:0]  state_q;
   logic [STATE_W-1:0]  state_d;
   logic [c_mask_w-1:0] birth_q;
   logic [c_mask_w-1:0] survive_q;
   logic [AGE_W-1:0]    age_q;
   logic [AGE_W-1:0]    age_d;
   logic [CNT_W-1:0]    w_living_count;
   logic [STATE_W-1:0]  w_state_0_safe;

   neighbor_popcount #(
      .N_NEIGHBORS (N_NEIGHBORS),
      .CNT_W       (CNT_W)
   ) u_popcount (
      .bits_i  (bus.neighbors),
      .count_o (w_living_count)
   );

   assign w_state_0_safe = ({1'b0, bus.state_0} >= c_n_states) ? c_st_dead : bus.state_0;

   // State register: reset wins over both advance and rule load.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= w_state_0_safe;
         age_q     <= '0;
         birth_q   <= DEFAULT_BIRTH;
         survive_q <= DEFAULT_SURVIVE;
      end else begin
         if (bus.ena) begin
            state_q <= state_d;
            age_q   <= age_d;
         end
         if (bus.rule_load) begin
            birth_q   <= bus.birth_in;
            survive_q <= bus.survive_in;
         end
      end
   end

   // Next-state: rules are read from the registers, so a load only affects the following cycle.
   always_comb begin
      state_d = c_st_dead;
      if (state_q == c_st_dead) begin
         state_d = birth_q[w_living_count] ? c_st_alive : c_st_dead;
      end else if (state_q == c_st_alive) begin
         state_d = survive_q[w_living_count] ? c_st_alive : c_st_after_alive;
      end else if ({1'b0, state_q} >= c_n_states) begin
         state_d = c_st_dead;
      end else if (state_q == c_st_last) begin
         state_d = c_st_dead;
      end else begin
         state_d = state_q + STATE_W'(1);
      end

      age_d = '0;
      if ((state_q == c_st_alive) && (state_d == c_st_alive)) begin
         age_d = (age_q == c_age_max) ? age_q : age_q + AGE_W'(1);
      end
   end

   always_comb begin
      bus.state_d      = state_d;
      bus.state_q      = state_q;
      bus.alive        = (state_q == c_st_alive);
      bus.living_count = w_living_count;
      bus.age_q        = age_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_generations_cell.sv
`default_nettype none
// ============================================================================
// tb_generations_cell : two cells (2-state and 4-state) against a rule model
// Rev 1.0
// ============================================================================
module tb_generations_cell;

   localparam logic [8:0] B3  = 9'h008;
   localparam logic [8:0] S23 = 9'h00C;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   generations_cell_if #(.N_NEIGHBORS(8), .STATE_W(1), .CNT_W(4), .AGE_W(4)) if2 ();
   generations_cell_if #(.N_NEIGHBORS(8), .STATE_W(3), .CNT_W(4), .AGE_W(4)) if4 ();

   generations_cell #(.N_NEIGHBORS(8), .N_STATES(2), .STATE_W(1), .CNT_W(4), .AGE_W(4)) dut2 (
      .clk (clk), .rst (rst), .bus (if2.slave)
   );

   generations_cell #(.N_NEIGHBORS(8), .N_STATES(4), .STATE_W(3), .CNT_W(4), .AGE_W(4)) dut4 (
      .clk (clk), .rst (rst), .bus (if4.slave)
   );

   // Generations rule: dead uses birth mask, alive uses survive mask, refractory counts up modulo N.
   function automatic int ref_next(input int st, input int c, input logic [8:0] b,
                                   input logic [8:0] s, input int ns);
      if (st == 0) return b[c] ? 1 : 0;
      if (st == 1) return s[c] ? 1 : ((ns > 2) ? 2 : 0);
      if (st >= ns) return 0;
      return (st + 1) % ns;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b1;
      if2.ena = 1'b0; if2.neighbors = '0; if2.state_0 = '0; if2.rule_load = 1'b0;
      if2.birth_in = '0; if2.survive_in = '0;
      if4.ena = 1'b0; if4.neighbors = '0; if4.state_0 = '0; if4.rule_load = 1'b0;
      if4.birth_in = '0; if4.survive_in = '0;
   endtask

   task automatic do_reset(input int s2, input int s4);
      if2.state_0 = 1'(s2);
      if4.state_0 = 3'(s4);
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      do_reset(0, 1);
      n_checks++;
      if (if2.state_q !== 1'b0) $display("FAIL reset_state2: got %0d expected 0", if2.state_q); else n_pass++;
      n_checks++;
      if (if2.age_q !== 4'd0) $display("FAIL reset_age2: got %0d expected 0", if2.age_q); else n_pass++;
      n_checks++;
      if (if4.state_q !== 3'd1) $display("FAIL reset_state4: got %0d expected 1", if4.state_q); else n_pass++;
      n_checks++;
      if (if4.alive !== 1'b1) $display("FAIL reset_alive4: got %0d expected 1", if4.alive); else n_pass++;
      n_checks++;
      if (if4.state_d !== 3'd2) $display("FAIL reset_default_survive: got %0d expected 2", if4.state_d); else n_pass++;
   endtask

   task automatic test_classic_sweep();
      int exp_d;
      int c;
      for (int start = 0; start < 2; start++) begin
         for (int n = 0; n < 256; n++) begin
            do_reset(start, 0);
            if2.ena       = 1'b1;
            if2.neighbors = 8'(n);
            #1;
            c     = $countones(8'(n));
            exp_d = ref_next(start, c, B3, S23, 2);
            n_checks++;
            if (if2.living_count !== 4'(c))
               $display("FAIL classic_count n=%0d: got %0d expected %0d", n, if2.living_count, c);
            else n_pass++;
            n_checks++;
            if (if2.state_d !== 1'(exp_d))
               $display("FAIL classic_state_d s=%0d n=%0d: got %0d expected %0d", start, n, if2.state_d, exp_d);
            else n_pass++;
            step();
            n_checks++;
            if (if2.state_q !== 1'(exp_d))
               $display("FAIL classic_state_q s=%0d n=%0d: got %0d expected %0d", start, n, if2.state_q, exp_d);
            else n_pass++;
         end
      end
      idle_inputs();
   endtask

   task automatic test_decay();
      int seq_a[4] = '{2, 3, 0, 0};
      int seq_b[3] = '{3, 0, 1};
      idle_inputs();
      do_reset(0, 1);
      if4.rule_load  = 1'b1;
      if4.birth_in   = B3;
      if4.survive_in = 9'h000;
      step();
      if4.rule_load = 1'b0;
      n_checks++;
      if (if4.state_q !== 3'd1) $display("FAIL decay_hold_on_load: got %0d expected 1", if4.state_q); else n_pass++;
      if4.neighbors = 8'h00;
      if4.ena       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (if4.state_q !== 3'(seq_a[i]))
            $display("FAIL decay_chain step%0d: got %0d expected %0d", i, if4.state_q, seq_a[i]);
         else n_pass++;
      end
      do_reset(0, 2);
      if4.neighbors = 8'h07;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (if4.state_q !== 3'(seq_b[i]))
            $display("FAIL refractory_no_birth step%0d: got %0d expected %0d", i, if4.state_q, seq_b[i]);
         else n_pass++;
      end
      idle_inputs();
   endtask

   task automatic test_rule_load_with_ena();
      idle_inputs();
      do_reset(0, 0);
      if2.neighbors  = 8'h03;
      if2.rule_load  = 1'b1;
      if2.birth_in   = 9'b000000100;
      if2.survive_in = S23;
      if2.ena        = 1'b1;
      #1;
      n_checks++;
      if (if2.state_d !== 1'b0) $display("FAIL load_old_rule_d: got %0d expected 0", if2.state_d); else n_pass++;
      step();
      if2.rule_load = 1'b0;
      n_checks++;
      if (if2.state_q !== 1'b0) $display("FAIL load_edge_state: got %0d expected 0", if2.state_q); else n_pass++;
      n_checks++;
      if (if2.state_d !== 1'b1) $display("FAIL load_new_rule_d: got %0d expected 1", if2.state_d); else n_pass++;
      step();
      n_checks++;
      if (if2.state_q !== 1'b1) $display("FAIL load_next_state: got %0d expected 1", if2.state_q); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_enable_hold();
      logic [7:0] v;
      idle_inputs();
      do_reset(1, 0);
      if2.neighbors = 8'h07;
      if2.ena       = 1'b1;
      repeat (3) step();
      if2.ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = 8'h00;
         for (int k = 0; k < 200 && $countones(v) < 3; k++) v = v | (8'h01 << $urandom_range(7, 0));
         if2.neighbors = v;
         #1;
         n_checks++;
         if (if2.living_count !== 4'd3) $display("FAIL hold_count: got %0d expected 3", if2.living_count); else n_pass++;
         n_checks++;
         if (if2.state_d !== 1'b1) $display("FAIL hold_state_d: got %0d expected 1", if2.state_d); else n_pass++;
         step();
         n_checks++;
         if (if2.state_q !== 1'b1) $display("FAIL hold_state_q: got %0d expected 1", if2.state_q); else n_pass++;
         n_checks++;
         if (if2.age_q !== 4'd3) $display("FAIL hold_age: got %0d expected 3", if2.age_q); else n_pass++;
      end
      idle_inputs();
   endtask

   task automatic test_age_saturation();
      int exp_age;
      idle_inputs();
      do_reset(1, 0);
      if2.neighbors = 8'h81;
      if2.ena       = 1'b1;
      n_checks++;
      if (if2.age_q !== 4'd0) $display("FAIL age_start: got %0d expected 0", if2.age_q); else n_pass++;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_age = (k < 15) ? k : 15;
         n_checks++;
         if (if2.age_q !== 4'(exp_age))
            $display("FAIL age_count k=%0d: got %0d expected %0d", k, if2.age_q, exp_age);
         else n_pass++;
      end
      if2.neighbors = 8'h00;
      step();
      n_checks++;
      if (if2.state_q !== 1'b0) $display("FAIL age_death_state: got %0d expected 0", if2.state_q); else n_pass++;
      n_checks++;
      if (if2.age_q !== 4'd0) $display("FAIL age_death_clear: got %0d expected 0", if2.age_q); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_reset_midrun();
      idle_inputs();
      do_reset(0, 1);
      if4.rule_load  = 1'b1;
      if4.birth_in   = 9'h004;
      if4.survive_in = 9'h004;
      step();
      if4.rule_load = 1'b0;
      if4.neighbors = 8'h11;
      if4.ena       = 1'b1;
      repeat (7) step();
      n_checks++;
      if (if4.age_q !== 4'd7) $display("FAIL midrun_age_before: got %0d expected 7", if4.age_q); else n_pass++;
      rst            = 1'b0;
      if4.rule_load  = 1'b1;
      if4.birth_in   = 9'h1FF;
      if4.survive_in = 9'h000;
      if4.state_0    = 3'd3;
      step();
      rst           = 1'b1;
      if4.rule_load = 1'b0;
      n_checks++;
      if (if4.state_q !== 3'd3) $display("FAIL midrun_state: got %0d expected 3", if4.state_q); else n_pass++;
      n_checks++;
      if (if4.age_q !== 4'd0) $display("FAIL midrun_age: got %0d expected 0", if4.age_q); else n_pass++;
      if4.neighbors = 8'h00;
      step();
      if4.neighbors = 8'h11;
      #1;
      n_checks++;
      if (if4.state_d !== 3'd0) $display("FAIL midrun_birth_mask_c2: got %0d expected 0", if4.state_d); else n_pass++;
      if4.neighbors = 8'h07;
      #1;
      n_checks++;
      if (if4.state_d !== 3'd1) $display("FAIL midrun_birth_mask_c3: got %0d expected 1", if4.state_d); else n_pass++;
      step();
      if4.neighbors = 8'h11;
      #1;
      n_checks++;
      if (if4.state_d !== 3'd1) $display("FAIL midrun_survive_c2: got %0d expected 1", if4.state_d); else n_pass++;
      if4.neighbors = 8'h0F;
      #1;
      n_checks++;
      if (if4.state_d !== 3'd2) $display("FAIL midrun_survive_c4: got %0d expected 2", if4.state_d); else n_pass++;
      do_reset(0, 5);
      n_checks++;
      if (if4.state_q !== 3'd0) $display("FAIL reset_state0_5: got %0d expected 0", if4.state_q); else n_pass++;
      do_reset(0, 3);
      n_checks++;
      if (if4.state_q !== 3'd3) $display("FAIL reset_state0_3: got %0d expected 3", if4.state_q); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_random();
      int         m_st, m_age, exp_d, c, s0;
      logic [8:0] m_b, m_s;
      logic       r_ena, r_load, r_rst;
      logic [8:0] r_bin, r_sin;
      idle_inputs();
      do_reset(0, 0);
      m_st = 0; m_age = 0; m_b = B3; m_s = S23;
      for (int it = 0; it < 600; it++) begin
         r_rst  = ($urandom_range(99) >= 3);
         s0     = $urandom_range(7);
         r_ena  = ($urandom_range(3) != 0);
         r_load = ($urandom_range(9) == 0);
         r_bin  = 9'($urandom);
         r_sin  = ($urandom_range(2) == 0) ? 9'h1FF : 9'($urandom);
         rst = r_rst;
         if4.state_0 = 3'(s0); if4.ena = r_ena; if4.rule_load = r_load;
         if4.birth_in = r_bin; if4.survive_in = r_sin;
         if4.neighbors = 8'($urandom);
         #1;
         c     = $countones(if4.neighbors);
         exp_d = ref_next(m_st, c, m_b, m_s, 4);
         n_checks++;
         if (if4.living_count !== 4'(c))
            $display("FAIL rand_count it=%0d: got %0d expected %0d", it, if4.living_count, c);
         else n_pass++;
         n_checks++;
         if (if4.state_d !== 3'(exp_d))
            $display("FAIL rand_state_d it=%0d: got %0d expected %0d", it, if4.state_d, exp_d);
         else n_pass++;
         step();
         if (!r_rst) begin
            m_st = (s0 < 4) ? s0 : 0; m_age = 0; m_b = B3; m_s = S23;
         end else begin
            if (r_ena) begin
               m_age = (m_st == 1 && exp_d == 1) ? ((m_age < 15) ? m_age + 1 : 15) : 0;
               m_st  = exp_d;
            end
            if (r_load) begin
               m_b = r_bin; m_s = r_sin;
            end
         end
         n_checks++;
         if (if4.state_q !== 3'(m_st))
            $display("FAIL rand_state_q it=%0d: got %0d expected %0d", it, if4.state_q, m_st);
         else n_pass++;
         n_checks++;
         if (if4.age_q !== 4'(m_age))
            $display("FAIL rand_age it=%0d: got %0d expected %0d", it, if4.age_q, m_age);
         else n_pass++;
         n_checks++;
         if (if4.alive !== (m_st == 1))
            $display("FAIL rand_alive it=%0d: got %0d expected %0d", it, if4.alive, (m_st == 1));
         else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1'b0;
      step();
      test_reset();
      test_classic_sweep();
      test_decay();
      test_rule_load_with_ena();
      test_enable_hold();
      test_age_saturation();
      test_reset_midrun();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/generations_cell.md
Name: generations_cell

Overview:
Parametrised successor to the fixed-rule Life cell for the game-of-life array. It is a programmable "Generations" cellular-automaton cell with the following features:
- Run-time birth/survive rule masks.
- Multi-state decay: dead, alive, then N_STATES-2 refractory states.
- Configurable neighbour count.
- A saturating age counter.

One instance sits at each grid position. Its alive output feeds the neighbours' neighbour inputs.

Parameters:
N_NEIGHBORS, 8, number of neighbour alive bits (8 = Moore, 4 = von Neumann)
N_STATES, 2, total cell states, must be >= 2 (2 = classic Life)
STATE_W, $clog2(N_STATES) min 1, state encoding width
CNT_W, $clog2(N_NEIGHBORS+1), living-neighbour count width
AGE_W, 4, age counter width
DEFAULT_BIRTH, B3 mask, reset birth mask (N_NEIGHBORS+1 bits, bit k = born with k neighbours)
DEFAULT_SURVIVE, S23 mask, reset survive mask

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset (rst=0 at posedge resets)
ena  in  1  generation advance enable
neighbors  in  N_NEIGHBORS  alive bits of the neighbours
state_0  in  STATE_W  state loaded at reset
rule_load  in  1  latch new rule masks
birth_in  in  N_NEIGHBORS+1  new birth mask
survive_in  in  N_NEIGHBORS+1  new survive mask
state_d  out  STATE_W  combinational next state
state_q  out  STATE_W  registered state
alive  out  1  state_q == 1
living_count  out  CNT_W  popcount(neighbors), combinational
age_q  out  AGE_W  consecutive generations alive, saturating

Behaviour:
- State encoding: 0 = dead, 1 = alive, 2..N_STATES-1 = refractory. Refractory cells are not alive and cannot be born.
- Next-state function (state_d), combinational from state_q, living_count (c) and the active rule registers:
  - state_q == 0: birth_r[c] ? 1 : 0.
  - state_q == 1: survive_r[c] ? 1 : (N_STATES == 2 ? 0 : 2).
  - state_q >= 2: state_q == N_STATES-1 ? 0 : state_q+1. Neighbours are ignored.
  - state_q >= N_STATES (unreachable; defensive): 0.
- Reset (rst=0 at posedge):
  - state_q <= state_0, or 0 if state_0 >= N_STATES.
  - birth_r <= DEFAULT_BIRTH; survive_r <= DEFAULT_SURVIVE.
  - age_q <= 0.
  - Reset overrides ena and rule_load. Reset mid-run takes effect on the next posedge regardless of other inputs.
- Advance (rst=1, ena=1): state_q <= state_d, so latency is one clock from neighbours to state_q.
- Hold (ena=0): state_q and age_q hold. state_d and living_count still track inputs combinationally.
- Rule load (rst=1, rule_load=1):
  - birth_r <= birth_in; survive_r <= survive_in. Independent of ena.
  - Simultaneous rule_load and ena: the state update uses the old rules. New rules affect state_d starting the cycle after the load edge.
- Age (on ena=1 advance):
  - state_q == 1 and state_d == 1: age_q <= min(age_q+1, 2^AGE_W-1), saturating with no wrap.
  - Otherwise: age_q <= 0. A newly born cell starts at age 0.
- Width rules:
  - living_count is zero-extended popcount; max value N_NEIGHBORS fits CNT_W.
  - Mask index c always lies in 0..N_NEIGHBORS, so no out-of-range indexing occurs.
- With N_STATES=2 and default masks, the cell is bit-exact with the existing Life cell (state_q[0] equivalent).

Decomposition:
- Package life_pkg:
  - Cell-state constants (ST_DEAD=0, ST_ALIVE=1).
  - Default B3/S23 mask constants for 8 neighbours.
  - Helper function for the mask width (N_NEIGHBORS+1).
- One sub-module: neighbor_popcount. It is parametrised on N_NEIGHBORS and outputs a CNT_W count, reused by the array-level statistics logic.
- The rule regs, next-state logic and age counter stay in generations_cell.

Test Plan:
- Classic equivalence: N_STATES=2, defaults, state_0=0. Sweep neighbors 0..255 with ena=1; then repeat with the cell forced alive via reset with state_0=1. Required: state_d==1 iff popcount==3 (dead) or popcount in {2,3} (alive). Zero mismatches against the behavioural model.
- Decay chain: N_STATES=4, state_0=1, survive mask 0, neighbors=8'h00, ena=1. Required: state_q sequence 1→2→3→0→0. A refractory cell holds through neighbors=8'h07 (c=3) with no birth until it reaches 0.
- Rule load with simultaneous ena:
  - Setup: state_q=0, neighbors=8'h03 (c=2). Assert rule_load with birth_in=9'b000000100 (B2) and ena=1 in the same cycle.
  - Required at that edge: state_q stays 0 (old B3 rule applies).
  - Required at the next edge: state_q becomes 1.
- Enable hold: alive cell with c=3, ena=0 for 5 cycles. Required: state_q=1 and age_q unchanged. state_d and living_count=3 remain valid.
- Age saturation: AGE_W=4, stable alive cell (c=2), ena=1 for 20 cycles. Required: age_q counts 0..15, then stays at 15. A death cycle (c=0) gives age_q=0.
- Reset mid-run: rst=0 with ena=1 and rule_load=1 while age_q=7 and custom rules are loaded. Required after the edge: state_q=state_0, age_q=0, masks back to B3/S23. Additionally, state_0=5 with N_STATES=4 gives state_q=0.
